i2c_target: RTL and testbench

//  I2C target (responder) for the opposite end of the NPU's SDA/SCL initiator bus.

---
 rtl/i2c_target_if.sv | 24 ++
 rtl/i2c_target.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - I2C target bus lines and register-file port bundle
interface i2c_target_if #(
  parameter int REG_AW = 4
);
  logic              scl_in;
  logic              sda_in;
  logic              sda_oe;
  logic [REG_AW-1:0] reg_addr;
  logic              reg_wr_en;
  logic [7:0]        reg_wr_data;
  logic              reg_rd_en;
  logic [7:0]        reg_rd_data;
  logic              busy;

  modport slave (
    input  scl_in, sda_in, reg_rd_data,
    output sda_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy
  );

  modport master (
    output scl_in, sda_in, reg_rd_data,
    input  sda_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy
  );
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - oversampling I2C target mapping bus transfers onto a register-file port
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         REG_AW      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  i2c_target_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR, RD_LOAD, RD, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic              rw, rw_n;
  logic              oe, oe_n;
  logic              busy_q, busy_n;
  logic [REG_AW-1:0] addr, addr_n;
  logic              wr_en, wr_en_n;
  logic [7:0]        wr_data, wr_data_n;
  logic              rd_en, rd_en_n;

  // Lines reset to the idle-high level so no edge is seen on reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      shreg   <= 8'd0;
      rw      <= 1'b0;
      oe      <= 1'b0;
      busy_q  <= 1'b0;
      addr    <= '0;
      wr_en   <= 1'b0;
      wr_data <= 8'd0;
      rd_en   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      rw      <= rw_n;
      oe      <= oe_n;
      busy_q  <= busy_n;
      addr    <= addr_n;
      wr_en   <= wr_en_n;
      wr_data <= wr_data_n;
      rd_en   <= rd_en_n;
    end
  end

  // cnt counts data bits 0..8; 9 marks the acknowledge clock of a byte.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    rw_n      = rw;
    oe_n      = oe;
    busy_n    = busy_q;
    addr_n    = addr;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data;
    rd_en_n   = 1'b0;
    if (start_c) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (stop_c) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WR: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_n = {shreg[6:0], sda_s};
            cnt_n   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = 4'd9;
            if (state == ADDR) begin
              if (shreg[7:1] == TARGET_ADDR) begin
                state_n = ADDR_ACK;
                oe_n    = 1'b1;
                busy_n  = 1'b1;
                rw_n    = shreg[0];
              end else begin
                state_n = IGNORE;
              end
            end else if (state == PTR) begin
              addr_n = shreg[REG_AW-1:0];
              oe_n   = 1'b1;
            end else begin
              wr_en_n   = 1'b1;
              wr_data_n = shreg;
              oe_n      = 1'b1;
            end
          end else if (scl_fall && cnt == 4'd9) begin
            cnt_n = 4'd0;
            oe_n  = 1'b0;
            if (state == PTR) begin
              state_n = WR;
            end else begin
              addr_n = addr + 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            oe_n  = 1'b0;
            cnt_n = 4'd0;
            if (rw) begin
              state_n = RD_LOAD;
              rd_en_n = 1'b1;
            end else begin
              state_n = PTR;
            end
          end
        end
        RD_LOAD: begin
          // reg_rd_data is valid one cycle after the strobe; first bit goes out with it.
          if (cnt == 4'd0) begin
            cnt_n = 4'd1;
          end else begin
            shreg_n = bus.reg_rd_data;
            oe_n    = ~bus.reg_rd_data[7];
            cnt_n   = 4'd0;
            state_n = RD;
          end
        end
        RD: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            oe_n    = 1'b0;
            cnt_n   = 4'd0;
            state_n = RD_ACK;
          end else if (scl_fall && cnt != 4'd0) begin
            oe_n    = ~shreg[6];
            shreg_n = {shreg[6:0], 1'b0};
          end
        end
        RD_ACK: begin
          // The pointer moves past every byte sent, whether or not it was acknowledged.
          if (scl_rise && cnt == 4'd0) begin
            addr_n = addr + 1'b1;
            if (sda_s) begin
              state_n = IGNORE;
              busy_n  = 1'b0;
            end else begin
              cnt_n = 4'd9;
            end
          end else if (scl_fall && cnt == 4'd9) begin
            cnt_n   = 4'd0;
            rd_en_n = 1'b1;
            state_n = RD_LOAD;
          end
        end
        IGNORE: oe_n = 1'b0;
        default: state_n = state;
      endcase
    end
  end

  assign bus.sda_oe      = oe;
  assign bus.reg_addr    = addr;
  assign bus.reg_wr_en   = wr_en;
  assign bus.reg_wr_data = wr_data;
  assign bus.reg_rd_en   = rd_en;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard bench driving I2C transfers into i2c_target
module tb_i2c_target;

  typedef struct {
    logic       is_wr;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] rd_data = 8'd0;
  logic [7:0] mem [16];
  logic       oe_seen = 1'b0;
  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;

  i2c_target_if #(.REG_AW(4)) bus ();

  assign bus.scl_in      = m_scl;
  assign bus.sda_in      = m_sda & ~bus.sda_oe;
  assign bus.reg_rd_data = rd_data;

  i2c_target #(.TARGET_ADDR(7'h42), .REG_AW(4), .SYNC_STAGES(2)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.reg_rd_en) rd_data <= mem[bus.reg_addr];
    if (bus.reg_wr_en) mem[bus.reg_addr] <= bus.reg_wr_data;
  end

  always @(negedge clk) begin
    ev_t e;
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.reg_wr_en || bus.reg_rd_en) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL strobe_unexpected got wr=%0b rd=%0b addr=%0d data=%02h want none",
                 bus.reg_wr_en, bus.reg_rd_en, bus.reg_addr, bus.reg_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (e.is_wr !== bus.reg_wr_en || e.is_wr === bus.reg_rd_en || e.addr !== bus.reg_addr ||
            (e.is_wr && e.data !== bus.reg_wr_data)) begin
          bad = bad + 1;
          $display("FAIL strobe got wr=%0b addr=%0d data=%02h want wr=%0b addr=%0d data=%02h",
                   bus.reg_wr_en, bus.reg_addr, bus.reg_wr_data, e.is_wr, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_wr, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = is_wr;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    tick(4); m_sda = b; tick(6); m_scl = 1'b1; tick(10); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(4); m_sda = 1'b1; tick(6); m_scl = 1'b1; tick(8); m_sda = 1'b0; tick(8); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(4); m_sda = 1'b0; tick(6); m_scl = 1'b1; tick(8); m_sda = 1'b1; tick(8);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(4); m_sda = 1'b1; tick(6); m_scl = 1'b1; tick(5);
    ack = ~bus.sda_in;
    tick(5); m_scl = 1'b0;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      tick(4); m_sda = 1'b1; tick(6); m_scl = 1'b1; tick(5);
      d[i] = bus.sda_in;
      tick(5); m_scl = 1'b0;
    end
    send_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) mem[i] = {4'(i), ~4'(i)};

    tick(3);
    check("rst_sda_oe", 32'(bus.sda_oe), 0);
    check("rst_reg_addr", 32'(bus.reg_addr), 0);
    check("rst_wr_en", 32'(bus.reg_wr_en), 0);
    check("rst_wr_data", 32'(bus.reg_wr_data), 0);
    check("rst_rd_en", 32'(bus.reg_rd_en), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    tick(5);

    // 1: pointer 3, two data bytes
    push(1'b1, 4'd3, 8'hA5);
    push(1'b1, 4'd4, 8'h5A);
    i2c_start();
    wr_byte(8'h84, ack); check("t1_ack_addr", 32'(ack), 1);
    check("t1_busy", 32'(bus.busy), 1);
    wr_byte(8'h03, ack); check("t1_ack_ptr", 32'(ack), 1);
    wr_byte(8'hA5, ack); check("t1_ack_d0", 32'(ack), 1);
    wr_byte(8'h5A, ack); check("t1_ack_d1", 32'(ack), 1);
    i2c_stop();
    check("t1_reg_addr", 32'(bus.reg_addr), 5);
    check("t1_busy_stop", 32'(bus.busy), 0);

    // 2: set pointer 2, repeated START, read two bytes
    push(1'b0, 4'd2, 8'h00);
    push(1'b0, 4'd3, 8'h00);
    i2c_start();
    wr_byte(8'h84, ack); check("t2_ack_addr", 32'(ack), 1);
    wr_byte(8'h02, ack); check("t2_ack_ptr", 32'(ack), 1);
    i2c_start();
    wr_byte(8'h85, ack); check("t2_ack_raddr", 32'(ack), 1);
    rd_byte(1'b0, d); check("t2_rd0", 32'(d), 32'h2D);
    rd_byte(1'b1, d); check("t2_rd1", 32'(d), 32'hA5);
    tick(4);
    check("t2_busy_nack", 32'(bus.busy), 0);
    check("t2_oe_nack", 32'(bus.sda_oe), 0);
    i2c_stop();
    check("t2_reg_addr", 32'(bus.reg_addr), 4);
    check("t2_busy_stop", 32'(bus.busy), 0);

    // 3: foreign address
    oe_seen = 1'b0;
    i2c_start();
    wr_byte(8'h90, ack); check("t3_nack_addr", 32'(ack), 0);
    wr_byte(8'h12, ack); check("t3_nack_data", 32'(ack), 0);
    check("t3_busy", 32'(bus.busy), 0);
    i2c_stop();
    check("t3_oe_never", 32'(oe_seen), 0);
    check("t3_reg_addr", 32'(bus.reg_addr), 4);

    // 4: pointer wrap
    push(1'b1, 4'd15, 8'h11);
    push(1'b1, 4'd0, 8'h22);
    i2c_start();
    wr_byte(8'h84, ack); check("t4_ack_addr", 32'(ack), 1);
    wr_byte(8'h0F, ack); check("t4_ack_ptr", 32'(ack), 1);
    wr_byte(8'h11, ack); check("t4_ack_d0", 32'(ack), 1);
    wr_byte(8'h22, ack); check("t4_ack_d1", 32'(ack), 1);
    i2c_stop();
    check("t4_reg_addr", 32'(bus.reg_addr), 1);

    // 5: STOP after half a data byte
    i2c_start();
    wr_byte(8'h84, ack); check("t5_ack_addr", 32'(ack), 1);
    wr_byte(8'h07, ack); check("t5_ack_ptr", 32'(ack), 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    check("t5_oe", 32'(bus.sda_oe), 0);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_reg_addr", 32'(bus.reg_addr), 7);

    // 6: reset while the target is pulling SDA for a read bit (mem[7]=0x78, MSB 0)
    push(1'b0, 4'd7, 8'h00);
    i2c_start();
    wr_byte(8'h85, ack); check("t6_ack_addr", 32'(ack), 1);
    tick(8);
    check("t6_oe_driving", 32'(bus.sda_oe), 1);
    rst_n = 1'b0;
    #1;
    check("t6_oe_reset", 32'(bus.sda_oe), 0);
    check("t6_addr_reset", 32'(bus.reg_addr), 0);
    check("t6_busy_reset", 32'(bus.busy), 0);
    check("t6_rd_en_reset", 32'(bus.reg_rd_en), 0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(10);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
